// File: rtl/grid_line_clear_pkg.sv
// grid_line_clear_pkg: playfield geometry, empty-cell code and line-clear FSM encoding
package grid_line_clear_pkg;
    localparam int GRID_COLS = 10;
    localparam int GRID_ROWS = 20;
    localparam logic [7:0] EMPTY_CELL = 8'h00;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SC_RD  = 3'd1;
    localparam logic [2:0] S_SC_EV  = 3'd2;
    localparam logic [2:0] S_SH_RD  = 3'd3;
    localparam logic [2:0] S_SH_WR  = 3'd4;
    localparam logic [2:0] S_CLR_WR = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
endpackage

// File: rtl/grid_line_clear.sv
// grid_line_clear: scans the playfield bottom-up and collapses full rows through Grid_Mem port A
module grid_line_clear #(
    parameter int GRID_COLS = grid_line_clear_pkg::GRID_COLS,
    parameter int GRID_ROWS = grid_line_clear_pkg::GRID_ROWS,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared,
    output logic [ADDR_W-1:0] grid_addr,
    output logic [DATA_W-1:0] grid_wdata,
    output logic              grid_we,
    input  logic [DATA_W-1:0] grid_rdata
);
    import grid_line_clear_pkg::*;
    localparam int RW = $clog2(GRID_ROWS);
    localparam int CW = $clog2(GRID_COLS);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GRID_COLS);
    logic [2:0]        state;
    logic [RW-1:0]     row, dst;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] row_base, dst_base;
    logic              last_col, cell_empty;
    assign last_col   = col == CW'(GRID_COLS - 1);
    assign cell_empty = grid_rdata == DATA_W'(EMPTY_CELL);
    // row_base tracks row*GRID_COLS and dst_base tracks dst*GRID_COLS, so no multiplier is needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            row           <= '0;
            dst           <= '0;
            col           <= '0;
            row_base      <= '0;
            dst_base      <= '0;
            lines_cleared <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state         <= S_SC_RD;
                    row           <= RW'(GRID_ROWS - 1);
                    row_base      <= ADDR_W'((GRID_ROWS - 1) * GRID_COLS);
                    col           <= '0;
                    lines_cleared <= '0;
                end
                S_SC_RD: state <= S_SC_EV;
                S_SC_EV: if (cell_empty) begin
                    col <= '0;
                    if (row == '0) state <= S_DONE;
                    else begin
                        row      <= row - 1'b1;
                        row_base <= row_base - ROW_STEP;
                        state    <= S_SC_RD;
                    end
                end else if (!last_col) begin
                    col   <= col + 1'b1;
                    state <= S_SC_RD;
                end else begin
                    lines_cleared <= lines_cleared + 5'(lines_cleared != 5'd31);
                    dst           <= row;
                    dst_base      <= row_base;
                    col           <= '0;
                    state         <= row == '0 ? S_CLR_WR : S_SH_RD;
                end
                S_SH_RD: state <= S_SH_WR;
                S_SH_WR: if (!last_col) begin
                    col   <= col + 1'b1;
                    state <= S_SH_RD;
                end else begin
                    col      <= '0;
                    dst      <= dst - 1'b1;
                    dst_base <= dst_base - ROW_STEP;
                    state    <= dst > RW'(1) ? S_SH_RD : S_CLR_WR;
                end
                // the same row is re-scanned afterwards since a full row may have dropped into it
                S_CLR_WR: begin
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col) state <= S_SC_RD;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    always_comb begin
        busy       = state != S_IDLE;
        done       = state == S_DONE;
        grid_we    = state == S_SH_WR || state == S_CLR_WR;
        grid_wdata = state == S_SH_WR ? grid_rdata : '0;
        grid_addr  = state == S_SC_RD  ? row_base + ADDR_W'(col) :
                     state == S_SH_RD  ? dst_base - ROW_STEP + ADDR_W'(col) :
                     state == S_SH_WR  ? dst_base + ADDR_W'(col) :
                     state == S_CLR_WR ? ADDR_W'(col) : '0;
    end
endmodule

// File: tb/tb_grid_line_clear.sv
// tb_grid_line_clear: Grid_Mem model plus row-compaction reference model for grid_line_clear
module tb_grid_line_clear;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int N    = COLS * ROWS;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, grid_we;
    logic [4:0] lines_cleared;
    logic [7:0] grid_addr, grid_wdata, grid_rdata;
    logic [7:0] mem[N];
    logic [7:0] img[N];
    logic [7:0] exp_mem[N];
    logic       load = 1'b0;
    int errors = 0, checks = 0;
    int exp_cnt = 0, exp_lines = 0, done_cnt = 0, we_cnt = 0, e = 0, d0 = 0;
    bit mon_en = 0, in_pass = 0, prev_done = 0;
    always #10 clk = ~clk;
    grid_line_clear dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .grid_addr(grid_addr), .grid_wdata(grid_wdata),
        .grid_we(grid_we), .grid_rdata(grid_rdata)
    );
    always @(posedge clk) begin
        if (load) for (int i = 0; i < N; i++) mem[i] <= img[i];
        else if (grid_we) mem[grid_addr] <= grid_wdata;
        grid_rdata <= mem[grid_addr];
    end
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    always @(negedge clk) if (mon_en) begin
        if (in_pass) begin
            check("busy_in_pass", int'(busy), 1);
            if (grid_we) begin
                we_cnt++;
                check("we_addr_range", int'(grid_addr < N), 1);
            end
            if (done) begin
                done_cnt++;
                check("done_width", int'(prev_done), 0);
            end
        end else begin
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done), 0);
            check("idle_we", int'(grid_we), 0);
            check("idle_lines", int'(lines_cleared), exp_lines);
        end
        prev_done = done;
    end
    // reference: keep non-full rows in order, pack them to the bottom, zero-fill the top
    task automatic model();
        int w;
        bit full;
        exp_cnt = 0;
        w = ROWS - 1;
        for (int i = 0; i < N; i++) exp_mem[i] = 8'h00;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1;
            for (int c = 0; c < COLS; c++) if (mem[r*COLS+c] == 8'h00) full = 0;
            if (full) exp_cnt++;
            else begin
                for (int c = 0; c < COLS; c++) exp_mem[w*COLS+c] = mem[r*COLS+c];
                w--;
            end
        end
    endtask
    task automatic clear_img();
        for (int i = 0; i < N; i++) img[i] = 8'h00;
    endtask
    task automatic fill_row(input int r, input logic [7:0] v);
        for (int c = 0; c < COLS; c++) img[r*COLS+c] = v;
    endtask
    task automatic load_img();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask
    task automatic run_pass(input bit repulse, output int edges);
        int bad;
        model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1 start = 1'b0;
        in_pass = 1;
        while (!done && edges < 20000) begin
            @(posedge clk);
            edges++;
            #1;
            if (repulse) start = edges == 6;
        end
        start = 1'b0;
        check("done_reached", int'(done), 1);
        @(posedge clk);
        #1;
        exp_lines = exp_cnt;
        in_pass = 0;
        check("lines_vs_model", int'(lines_cleared), exp_cnt);
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== exp_mem[i]) bad++;
        check("grid_vs_model", bad, 0);
    endtask
    initial begin
        int n, nz;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_lines", int'(lines_cleared), 0);
        check("rst_addr", int'(grid_addr), 0);
        check("rst_wdata", int'(grid_wdata), 0);
        check("rst_we", int'(grid_we), 0);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1;
        clear_img();
        load_img();
        we_cnt = 0;
        run_pass(0, e);
        check("t1_done_edge", e, 41);
        check("t1_no_writes", we_cnt, 0);
        check("t1_lines", int'(lines_cleared), 0);
        clear_img();
        fill_row(19, 8'h01);
        img[183] = 8'h05;
        load_img();
        run_pass(0, e);
        check("t2_lines", int'(lines_cleared), 1);
        check("t2_addr193", int'(mem[193]), 8'h05);
        clear_img();
        fill_row(19, 8'h03);
        fill_row(18, 8'h03);
        img[170] = 8'h02;
        load_img();
        run_pass(0, e);
        check("t3_lines", int'(lines_cleared), 2);
        check("t3_addr190", int'(mem[190]), 8'h02);
        clear_img();
        fill_row(19, 8'h01);
        fill_row(17, 8'h04);
        img[180] = 8'h07;
        load_img();
        run_pass(0, e);
        check("t4_lines", int'(lines_cleared), 2);
        check("t4_addr190", int'(mem[190]), 8'h07);
        clear_img();
        fill_row(19, 8'h06);
        img[181] = 8'h0A;
        load_img();
        d0 = done_cnt;
        run_pass(1, e);
        repeat (6) @(posedge clk);
        #1;
        check("t5_done_pulses", done_cnt - d0, 1);
        check("t5_lines", int'(lines_cleared), 1);
        clear_img();
        fill_row(19, 8'h09);
        img[182] = 8'h04;
        load_img();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_pass = 1;
        n = 0;
        while (!grid_we && n < 1000) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("t6_reached_write", int'(grid_we), 1);
        #2 mon_en = 0;
        reset = 1'b1;
        #1;
        check("t6_abort_busy", int'(busy), 0);
        check("t6_abort_done", int'(done), 0);
        check("t6_abort_we", int'(grid_we), 0);
        @(negedge clk);
        reset = 1'b0;
        in_pass = 0;
        prev_done = 0;
        exp_lines = 0;
        mon_en = 1;
        run_pass(0, e);
        check("t6_lines", int'(lines_cleared), 1);
        check("t6_addr192", int'(mem[192]), 8'h04);
        for (int i = 0; i < N; i++) img[i] = 8'hFF;
        load_img();
        run_pass(0, e);
        check("t7_lines", int'(lines_cleared), 20);
        nz = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== 8'h00) nz++;
        check("t7_all_zero", nz, 0);
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
